// File: rtl/acq_sequencer.sv
// Run sequencer for the sampling datapath: latches configuration, flushes the datapath,
// waits for an optional probe trigger, gates acquisition and ends the run on stop, limit or stall.
module acq_sequencer #(
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [7:0]       cfg_divisor,
    input  logic [15:0]      cfg_chan_enable,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic [15:0]      cfg_trig_mask,
    input  logic [15:0]      cfg_trig_value,
    input  logic [15:0]      probe_synced,
    input  logic             sample_data_avail,
    input  logic             stalled,
    output logic             dp_rst,
    output logic             acq_enable,
    output logic [7:0]       clock_divisor,
    output logic [15:0]      channel_enable,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic             err_cfg,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] STAT_NONE  = 2'b00;
    localparam logic [1:0] STAT_LIMIT = 2'b01;
    localparam logic [1:0] STAT_STOP  = 2'b10;
    localparam logic [1:0] STAT_OVF   = 2'b11;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    // Counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_flush_cnt;
    logic [3:0]       w_next_flush;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] w_next_limit;
    logic [15:0]      r_trig_mask;
    logic [15:0]      w_next_tmask;
    logic [15:0]      r_trig_value;
    logic [15:0]      w_next_tvalue;
    logic             r_dp_rst;
    logic             r_acq_enable;
    logic [7:0]       r_clock_divisor;
    logic [7:0]       w_next_div;
    logic [15:0]      r_channel_enable;
    logic [15:0]      w_next_chan;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_status;
    logic [1:0]       w_next_status;
    logic             r_err_cfg;
    logic             w_next_err;
    logic [CNT_W-1:0] r_word_count;
    logic [CNT_W-1:0] w_next_count;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_trig_hit;

    assign w_count_inc = sat_inc(r_word_count);
    assign w_trig_hit  = ((probe_synced & r_trig_mask) == (r_trig_value & r_trig_mask));

    // Next-state and next-register-value decode.
    always_comb begin
        w_next_state  = r_state;
        w_next_flush  = r_flush_cnt;
        w_next_limit  = r_limit;
        w_next_tmask  = r_trig_mask;
        w_next_tvalue = r_trig_value;
        w_next_div    = r_clock_divisor;
        w_next_chan   = r_channel_enable;
        w_next_status = r_status;
        w_next_err    = r_err_cfg;
        w_next_count  = r_word_count;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // A simultaneous stop cancels the start request outright.
                if (cmd_stop) begin
                    w_next_state = r_state;
                end else if (cmd_start) begin
                    if (cfg_chan_enable == 16'h0000) begin
                        w_next_err = 1'b1;
                    end else begin
                        w_next_div    = cfg_divisor;
                        w_next_chan   = cfg_chan_enable;
                        w_next_limit  = cfg_limit;
                        w_next_tmask  = cfg_trig_mask;
                        w_next_tvalue = cfg_trig_value;
                        w_next_count  = {CNT_W{1'b0}};
                        w_next_status = STAT_NONE;
                        w_next_err    = 1'b0;
                        w_next_flush  = 4'd0;
                        w_next_state  = ST_FLUSH;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_FLUSH: begin
                if (cmd_stop) begin
                    w_next_status = STAT_STOP;
                    w_next_state  = ST_DONE;
                end else if (r_flush_cnt == FLUSH_LAST) begin
                    w_next_state = ST_ARMED;
                end else begin
                    w_next_flush = r_flush_cnt + 4'd1;
                end
            end
            ST_ARMED: begin
                if (cmd_stop) begin
                    w_next_status = STAT_STOP;
                    w_next_state  = ST_DONE;
                end else if (w_trig_hit) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_RUN: begin
                // A word arriving in the exit cycle is still counted.
                if (sample_data_avail) begin
                    w_next_count = w_count_inc;
                end else begin
                    w_next_count = r_word_count;
                end
                if (stalled) begin
                    w_next_status = STAT_OVF;
                    w_next_state  = ST_DONE;
                end else if (cmd_stop) begin
                    w_next_status = STAT_STOP;
                    w_next_state  = ST_DONE;
                end else if (sample_data_avail && (r_limit != {CNT_W{1'b0}}) &&
                             (w_count_inc == r_limit)) begin
                    w_next_status = STAT_LIMIT;
                    w_next_state  = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state and flush counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_flush;
        end
    end

    // Latched run configuration and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_limit          <= {CNT_W{1'b0}};
            r_trig_mask      <= 16'h0000;
            r_trig_value     <= 16'h0000;
            r_clock_divisor  <= 8'h00;
            r_channel_enable <= 16'h0000;
            r_dp_rst         <= 1'b0;
            r_acq_enable     <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_status         <= STAT_NONE;
            r_err_cfg        <= 1'b0;
            r_word_count     <= {CNT_W{1'b0}};
        end else begin
            r_limit          <= w_next_limit;
            r_trig_mask      <= w_next_tmask;
            r_trig_value     <= w_next_tvalue;
            r_clock_divisor  <= w_next_div;
            r_channel_enable <= w_next_chan;
            r_dp_rst         <= (w_next_state == ST_FLUSH);
            r_acq_enable     <= (w_next_state == ST_RUN);
            r_busy           <= (w_next_state == ST_FLUSH) || (w_next_state == ST_ARMED) ||
                                (w_next_state == ST_RUN);
            r_done           <= (w_next_state == ST_DONE);
            r_status         <= w_next_status;
            r_err_cfg        <= w_next_err;
            r_word_count     <= w_next_count;
        end
    end

    assign dp_rst         = r_dp_rst;
    assign acq_enable     = r_acq_enable;
    assign clock_divisor  = r_clock_divisor;
    assign channel_enable = r_channel_enable;
    assign busy           = r_busy;
    assign done           = r_done;
    assign status         = r_status;
    assign err_cfg        = r_err_cfg;
    assign word_count     = r_word_count;

endmodule
